// File: rtl/wb_master_queue_pkg.sv
// Shared bus widths and the chunk record stored per queue entry.
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef GRANULARITY
`define GRANULARITY 8
`endif
`ifndef CHUNK_WIDTH
`define CHUNK_WIDTH (`BUS_ADDRESS_WIDTH + `BUS_DATA_WIDTH + `BUS_DATA_WIDTH / `GRANULARITY)
`endif

package wb_master_queue_pkg;

   localparam int unsigned BusAddrW = `BUS_ADDRESS_WIDTH;
   localparam int unsigned BusDataW = `BUS_DATA_WIDTH;
   localparam int unsigned BusSelW  = `BUS_DATA_WIDTH / `GRANULARITY;
   localparam int unsigned ChunkBits = `CHUNK_WIDTH;

   typedef struct packed {
      logic [BusAddrW-1:0] address;
      logic [BusDataW-1:0] data;
      logic [BusSelW-1:0]  sel;
   } chunk_t;

endpackage

// File: rtl/wb_master_queue_ram.sv
// Simple dual-port array: synchronous write, asynchronous read.
module wb_master_queue_ram #(
   parameter int unsigned Depth = 32,
   parameter int unsigned Width = 68
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(Depth)-1:0] waddr,
   input  logic [Width-1:0]         wdata,
   input  logic [$clog2(Depth)-1:0] raddr,
   output logic [Width-1:0]         rdata
);

   logic [Width-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/wb_master_queue.sv
// Whole-message queue in front of the WISHBONE master: chunk writes in, head message
// chunk presented combinationally, with advance / pop / rewind controls.
module wb_master_queue
   import wb_master_queue_pkg::*;
#(
   parameter int unsigned N_MESSAGES          = 4,
   parameter int unsigned N_CHUNKS_MAX        = 8,
   parameter int unsigned N_BITS_BURST_LENGHT = 7
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       wr_valid_i,
   output logic                                       wr_ready_o,
   input  logic [`BUS_ADDRESS_WIDTH-1:0]              wr_address_i,
   input  logic [`BUS_DATA_WIDTH-1:0]                 wr_data_i,
   input  logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0]    wr_sel_i,
   input  logic                                       wr_we_i,
   input  logic                                       wr_last_i,
   output logic                                       r_bus_arbitration_o,
   output logic [`BUS_ADDRESS_WIDTH-1:0]              address_o,
   output logic [`BUS_DATA_WIDTH-1:0]                 data_o,
   output logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0]    sel_o,
   output logic                                       transaction_type_o,
   output logic [N_BITS_BURST_LENGHT-1:0]             burst_lenght_o,
   input  logic                                       next_data_i,
   input  logic                                       message_transmitted_i,
   input  logic                                       retry_i,
   output logic                                       overflow_o,
   output logic [$clog2(N_MESSAGES):0]                n_messages_o
);

   localparam int unsigned SlotW  = $clog2(N_MESSAGES);
   localparam int unsigned ChunkW = $clog2(N_CHUNKS_MAX);
   localparam int unsigned CntW   = SlotW + 1;
   localparam int unsigned LenW   = N_BITS_BURST_LENGHT;
   localparam int unsigned Depth  = N_MESSAGES * N_CHUNKS_MAX;

   // wr_chunk needs one extra bit to reach N_CHUNKS_MAX, the overflow marker.
   logic [SlotW-1:0]  wr_slot_q, wr_slot_d;
   logic [ChunkW:0]   wr_chunk_q, wr_chunk_d;
   logic [SlotW-1:0]  rd_slot_q, rd_slot_d;
   logic [ChunkW-1:0] rd_chunk_q, rd_chunk_d;
   logic [CntW-1:0]   n_q, n_d;
   logic              overflow_q, overflow_d;

   logic              desc_we_q  [N_MESSAGES];
   logic [LenW-1:0]   desc_len_q [N_MESSAGES];

   logic              wr_accept, chunk_full, ram_we, commit, pop, not_empty;
   logic [LenW-1:0]   commit_len, rd_chunk_inc;
   chunk_t            wr_chunk_s, rd_chunk_s;

   assign not_empty  = (n_q != '0);
   assign wr_ready_o = (n_q < CntW'(N_MESSAGES));
   assign wr_accept  = wr_valid_i & wr_ready_o;
   assign chunk_full = (wr_chunk_q == (ChunkW+1)'(N_CHUNKS_MAX));
   assign ram_we     = wr_accept & ~chunk_full;
   assign commit     = wr_accept & wr_last_i;
   assign pop        = message_transmitted_i & not_empty;
   assign commit_len = chunk_full ? LenW'(N_CHUNKS_MAX) : LenW'(wr_chunk_q) + LenW'(1);
   assign rd_chunk_inc = LenW'(rd_chunk_q) + LenW'(1);

   assign wr_chunk_s.address = wr_address_i;
   assign wr_chunk_s.data    = wr_data_i;
   assign wr_chunk_s.sel     = wr_sel_i;

   wb_master_queue_ram #(
      .Depth (Depth),
      .Width (ChunkBits)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr ({wr_slot_q, wr_chunk_q[ChunkW-1:0]}),
      .wdata (wr_chunk_s),
      .raddr ({rd_slot_q, rd_chunk_q}),
      .rdata (rd_chunk_s)
   );

   always_comb begin
      wr_slot_d  = wr_slot_q;
      wr_chunk_d = wr_chunk_q;
      overflow_d = overflow_q;
      if (wr_accept) begin
         if (wr_last_i) begin
            wr_slot_d  = wr_slot_q + 1'b1;
            wr_chunk_d = '0;
         end else if (chunk_full) begin
            overflow_d = 1'b1;
         end else begin
            wr_chunk_d = wr_chunk_q + 1'b1;
         end
      end
   end

   always_comb begin
      rd_slot_d  = rd_slot_q;
      rd_chunk_d = rd_chunk_q;
      if (not_empty) begin
         if (message_transmitted_i) begin
            rd_slot_d  = rd_slot_q + 1'b1;
            rd_chunk_d = '0;
         end else if (retry_i) begin
            rd_chunk_d = '0;
         end else if (next_data_i && (rd_chunk_inc < desc_len_q[rd_slot_q])) begin
            rd_chunk_d = rd_chunk_q + 1'b1;
         end
      end
   end

   always_comb begin
      n_d = n_q;
      case ({commit, pop})
         2'b10:   n_d = n_q + 1'b1;
         2'b01:   n_d = n_q - 1'b1;
         default: n_d = n_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_slot_q  <= '0;
         wr_chunk_q <= '0;
         rd_slot_q  <= '0;
         rd_chunk_q <= '0;
         n_q        <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_slot_q  <= wr_slot_d;
         wr_chunk_q <= wr_chunk_d;
         rd_slot_q  <= rd_slot_d;
         rd_chunk_q <= rd_chunk_d;
         n_q        <= n_d;
         overflow_q <= overflow_d;
      end
   end

   // Descriptors are invisible until commit, so they need no reset.
   always_ff @(posedge clk) begin
      if (wr_accept && (wr_chunk_q == '0)) begin
         desc_we_q[wr_slot_q] <= wr_we_i;
      end
      if (commit) begin
         desc_len_q[wr_slot_q] <= commit_len;
      end
   end

   assign r_bus_arbitration_o = not_empty;
   assign address_o           = rd_chunk_s.address;
   assign data_o              = rd_chunk_s.data;
   assign sel_o               = rd_chunk_s.sel;
   assign transaction_type_o  = desc_we_q[rd_slot_q];
   assign burst_lenght_o      = desc_len_q[rd_slot_q];
   assign overflow_o          = overflow_q;
   assign n_messages_o        = n_q;

endmodule

// File: tb/tb_wb_master_queue.sv
// Randomized bench for wb_master_queue against a message-level queue model.
module tb_wb_master_queue;
   import wb_master_queue_pkg::*;

   localparam int NMsg = 4;
   localparam int NCh  = 8;

   logic                clk, rst;
   logic                wr_valid, wr_ready, wr_we, wr_last;
   logic [BusAddrW-1:0] wr_address, address;
   logic [BusDataW-1:0] wr_data, data;
   logic [BusSelW-1:0]  wr_sel, sel;
   logic                r_bus_arbitration, transaction_type, overflow;
   logic [6:0]          burst_lenght;
   logic                next_data, message_transmitted, retry;
   logic [2:0]          n_messages;

   wb_master_queue #(
      .N_MESSAGES          (NMsg),
      .N_CHUNKS_MAX        (NCh),
      .N_BITS_BURST_LENGHT (7)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .wr_valid_i            (wr_valid),
      .wr_ready_o            (wr_ready),
      .wr_address_i          (wr_address),
      .wr_data_i             (wr_data),
      .wr_sel_i              (wr_sel),
      .wr_we_i               (wr_we),
      .wr_last_i             (wr_last),
      .r_bus_arbitration_o   (r_bus_arbitration),
      .address_o             (address),
      .data_o                (data),
      .sel_o                 (sel),
      .transaction_type_o    (transaction_type),
      .burst_lenght_o        (burst_lenght),
      .next_data_i           (next_data),
      .message_transmitted_i (message_transmitted),
      .retry_i               (retry),
      .overflow_o            (overflow),
      .n_messages_o          (n_messages)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Committed messages: chunks of all messages concatenated, head message first.
   logic [BusAddrW-1:0] m_addr[$];
   logic [BusDataW-1:0] m_data[$];
   logic [BusSelW-1:0]  m_sel[$];
   int                  m_len[$];
   logic                m_we[$];
   int                  m_rd;
   bit                  m_ovf;
   // Message under construction.
   logic [BusAddrW-1:0] p_addr[$];
   logic [BusDataW-1:0] p_data[$];
   logic [BusSelW-1:0]  p_sel[$];
   logic                p_we;

   task automatic model_reset();
      m_addr.delete(); m_data.delete(); m_sel.delete(); m_len.delete(); m_we.delete();
      p_addr.delete(); p_data.delete(); p_sel.delete();
      m_rd = 0;
      m_ovf = 0;
      p_we = 0;
   endtask

   // Applies the inputs currently driven, as the next clock edge will.
   task automatic model_edge();
      int  cnt;
      bit  acc;
      cnt = m_len.size();
      acc = wr_valid && (cnt < NMsg);
      if (cnt != 0) begin
         if (message_transmitted) begin
            for (int i = 0; i < m_len[0]; i++) begin
               void'(m_addr.pop_front());
               void'(m_data.pop_front());
               void'(m_sel.pop_front());
            end
            void'(m_len.pop_front());
            void'(m_we.pop_front());
            m_rd = 0;
         end else if (retry) begin
            m_rd = 0;
         end else if (next_data && (m_rd < m_len[0] - 1)) begin
            m_rd++;
         end
      end
      if (acc) begin
         if (p_addr.size() == 0) p_we = wr_we;
         if (p_addr.size() < NCh) begin
            p_addr.push_back(wr_address);
            p_data.push_back(wr_data);
            p_sel.push_back(wr_sel);
         end else if (!wr_last) begin
            m_ovf = 1;
         end
         if (wr_last) begin
            for (int i = 0; i < p_addr.size(); i++) begin
               m_addr.push_back(p_addr[i]);
               m_data.push_back(p_data[i]);
               m_sel.push_back(p_sel[i]);
            end
            m_len.push_back(p_addr.size());
            m_we.push_back(p_we);
            p_addr.delete(); p_data.delete(); p_sel.delete();
         end
      end
   endtask

   task automatic check_outputs();
      int cnt;
      cnt = m_len.size();
      check_eq("wr_ready", wr_ready, cnt < NMsg);
      check_eq("arb", r_bus_arbitration, cnt != 0);
      check_eq("n_messages", n_messages, cnt);
      check_eq("overflow", overflow, m_ovf);
      if (cnt != 0) begin
         check_eq("address", address, m_addr[m_rd]);
         check_eq("data", data, m_data[m_rd]);
         check_eq("sel", sel, m_sel[m_rd]);
         check_eq("we", transaction_type, m_we[0]);
         check_eq("burst", burst_lenght, m_len[0]);
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle_inputs();
      wr_valid = 0; wr_last = 0; wr_we = 0;
      wr_address = '0; wr_data = '0; wr_sel = '0;
      next_data = 0; message_transmitted = 0; retry = 0;
   endtask

   task automatic put_chunk(input logic [31:0] a, input logic we, input logic last);
      wr_valid = 1; wr_address = a; wr_data = ~a; wr_sel = a[3:0]; wr_we = we; wr_last = last;
   endtask

   task automatic run_random(input int cycles, input int last_div, input int pop_div);
      for (int c = 0; c < cycles; c++) begin
         wr_valid = ($urandom_range(0, 2) != 0);
         wr_address = $urandom();
         wr_data = $urandom();
         wr_sel = 4'($urandom());
         wr_we = 1'($urandom());
         wr_last = ($urandom_range(0, last_div - 1) == 0);
         message_transmitted = ($urandom_range(0, pop_div - 1) == 0);
         retry = ($urandom_range(0, 7) == 0);
         next_data = ($urandom_range(0, 1) == 0);
         cycle();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      model_reset();
      rst = 0;
      #22;
      check_eq("rst_arb", r_bus_arbitration, 0);
      check_eq("rst_n", n_messages, 0);
      check_eq("rst_ovf", overflow, 0);
      check_eq("rst_ready", wr_ready, 1);
      @(negedge clk);
      rst = 1;

      // Three-chunk write message, then walk, saturate, rewind and pop it.
      for (int i = 0; i < 3; i++) begin
         put_chunk(32'h10 + 32'(4 * i), 1'b1, i == 2);
         cycle();
      end
      idle_inputs();
      check_eq("plan_arb", r_bus_arbitration, 1);
      check_eq("plan_burst", burst_lenght, 3);
      check_eq("plan_addr0", address, 32'h10);
      check_eq("plan_we", transaction_type, 1);
      next_data = 1;
      cycle();
      cycle();
      check_eq("plan_addr2", address, 32'h18);
      cycle();
      check_eq("plan_sat", address, 32'h18);
      next_data = 0; retry = 1;
      cycle();
      check_eq("plan_retry", address, 32'h10);
      check_eq("plan_retry_n", n_messages, 1);
      retry = 0; message_transmitted = 1;
      cycle();
      check_eq("plan_pop_n", n_messages, 0);
      check_eq("plan_pop_arb", r_bus_arbitration, 0);
      idle_inputs();

      run_random(1500, 3, 4);
      run_random(1000, 4, 20);
      run_random(800, 14, 3);

      // Asynchronous reset while the second chunk of a message is being written.
      idle_inputs();
      put_chunk(32'h100, 1'b0, 1'b0);
      cycle();
      put_chunk(32'h104, 1'b0, 1'b0);
      @(negedge clk);
      rst = 0;
      #1;
      check_eq("arst_arb", r_bus_arbitration, 0);
      check_eq("arst_n", n_messages, 0);
      check_eq("arst_ovf", overflow, 0);
      check_eq("arst_ready", wr_ready, 1);
      idle_inputs();
      model_reset();
      @(negedge clk);
      rst = 1;
      put_chunk(32'h200, 1'b1, 1'b1);
      cycle();
      idle_inputs();
      check_eq("fresh_addr", address, 32'h200);
      check_eq("fresh_n", n_messages, 1);

      run_random(800, 3, 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_master_queue.md
Name: wb_master_queue

Overview:
Message queue directly upstream of the WISHBONE master interface. Accepts bus-transaction messages chunk by chunk from the NoC depacketizer. Stores whole messages and presents the head message's current chunk (address/data/sel/WE/burst length) to the master. Advances on next_data, pops on message_transmitted, and rewinds to chunk 0 on retry.

Parameters:
N_MESSAGES, 4, message slots (power of 2, >=2)
N_CHUNKS_MAX, 8, max chunks per message (power of 2)
N_BITS_BURST_LENGHT, 7, width of burst_lenght_o; must hold N_CHUNKS_MAX

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
wr_valid_i  in  1  producer has a chunk
wr_ready_o  out  1  queue accepts chunk this cycle
wr_address_i  in  `BUS_ADDRESS_WIDTH  chunk address
wr_data_i  in  `BUS_DATA_WIDTH  chunk data
wr_sel_i  in  `BUS_DATA_WIDTH/`GRANULARITY  chunk SEL
wr_we_i  in  1  transaction type, sampled on first chunk of message
wr_last_i  in  1  chunk closes the message
r_bus_arbitration_o  out  1  a complete message is at head
address_o  out  `BUS_ADDRESS_WIDTH  head message, current chunk
data_o  out  `BUS_DATA_WIDTH  head message, current chunk
sel_o  out  `BUS_DATA_WIDTH/`GRANULARITY  head message, current chunk
transaction_type_o  out  1  head message WE
burst_lenght_o  out  N_BITS_BURST_LENGHT  head message chunk count
next_data_i  in  1  advance to next chunk
message_transmitted_i  in  1  head message done, pop
retry_i  in  1  restart head message from chunk 0
overflow_o  out  1  sticky: chunks dropped by length overflow
n_messages_o  out  $clog2(N_MESSAGES)+1  committed messages held

Behaviour:
- Reset (rst=0, async): all pointers/counters 0, overflow_o=0, r_bus_arbitration_o=0, n_messages_o=0. Storage contents are not reset; outputs are don't-care while empty.
- Storage: chunk array of N_MESSAGES*N_CHUNKS_MAX entries {address,data,sel}, indexed {slot,chunk}. Per-slot descriptor {we,length}.
- Write side:
  - wr_ready_o = (n_messages_o < N_MESSAGES). Registered-count based only; a pop in the same cycle does not raise it.
  - Chunk is accepted on wr_valid_i & wr_ready_o. It is written to {wr_slot, wr_chunk}, and wr_chunk increments. First chunk (wr_chunk==0) latches wr_we_i.
  - On accepted wr_last_i: descriptor length = wr_chunk+1; wr_slot advances mod N_MESSAGES; wr_chunk=0. Message commits, and n_messages increments next cycle.
  - Overflow: accepted chunk with wr_chunk==N_CHUNKS_MAX and !wr_last_i is dropped, and overflow_o is set (sticky until reset). If wr_last_i is set, the data is dropped but the message still commits with length N_CHUNKS_MAX.
- Read side:
  - r_bus_arbitration_o = (n_messages_o != 0).
  - Outputs are combinational reads of {rd_slot, rd_chunk} and the rd_slot descriptor. Zero latency from pointer change to outputs.
  - next_data_i: rd_chunk increments, saturating at length-1.
  - message_transmitted_i: rd_slot advances mod N_MESSAGES; rd_chunk=0; n_messages decrements.
  - retry_i: rd_chunk=0; message is retained.
- Priority within a cycle:
  - message_transmitted_i > retry_i > next_data_i.
  - Read-side strobes while empty are ignored.
- Commit and pop in the same cycle leave n_messages unchanged.
- The master keeps r_bus_arbitration sampled in IDLE. A message is never visible before its last chunk is written, so a partial message is never presented.
- Pointer wrap: slot pointers are $clog2(N_MESSAGES) bits and wrap naturally. Full/empty are decided by n_messages, not by pointer equality.
- Reset mid-message discards partial and committed messages.

Decomposition:
- Reuse `BUS_ADDRESS_WIDTH, `BUS_DATA_WIDTH and `GRANULARITY from NIC-defines.v.
- Add a `CHUNK_WIDTH define (address+data+sel) there.
- One sub-module: wb_master_queue_ram, a simple dual-port array with a synchronous write port and an asynchronous read port. This keeps the option of mapping it to distributed RAM.

Test Plan:
- Write 3-chunk write message (addr 0x10,0x14,0x18; we=1) -> r_bus_arbitration_o=1 the cycle after the last chunk; burst_lenght_o=3; address_o=0x10. After 2 next_data_i pulses address_o=0x18; a third pulse keeps 0x18.
- Retry after 2 next_data_i -> address_o returns to 0x10; n_messages_o stays 1. message_transmitted_i then sets n_messages_o=0 and r_bus_arbitration_o=0.
- Fill 4 one-chunk messages -> wr_ready_o=0. A 5th chunk held with wr_valid_i is not accepted. Pop one -> wr_ready_o=1 next cycle; slot pointers wrap and the FIFO order is 1,2,3,4,5.
- Commit (wr_last_i) and message_transmitted_i in the same cycle with 2 held -> n_messages_o remains 2; next head is the correct message.
- 10-chunk message without earlier last, wr_last_i on chunk 10 -> overflow_o=1; burst_lenght_o=8; chunks 9-10 dropped.
- Assert rst low while a 2nd chunk is written -> all outputs 0 immediately (async). After release, queue is empty and accepts a fresh message.
